// File: rtl/modq_pkg.sv
// Shared constants, helpers and FSM states for the modulo-Q reducer.
// Imported by the reducer top and its compare-subtract step.
package modq_pkg;

  localparam int Q_DEFAULT = 3329;

  function automatic int qwidth(input int q);
    return $clog2(q + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/modq_csub_step.sv
// One restoring compare-subtract step: mag - (Q<<k) when it fits.
// Purely combinational; the top reuses it once per REDUCE cycle.
module modq_csub_step #(
  parameter int N  = 25,
  parameter int Q  = 3329,
  parameter int KW = 4
) (
  input  logic [N-1:0]  mag,
  input  logic [KW-1:0] k,
  output logic [N-1:0]  mag_nx
);

  localparam logic [N:0] Q_X = (N+1)'(Q);

  logic [N:0]   d;
  logic [N:0]   m;
  logic [N-1:0] diff;

  // d is one bit wider than mag so the top shift never truncates;
  // when m >= d the top bit of d is zero, so an N-bit diff is exact.
  always_comb begin
    d      = Q_X << k;
    m      = {1'b0, mag};
    diff   = mag - d[N-1:0];
    mag_nx = (m >= d) ? diff : mag;
  end

endmodule

// File: rtl/modq_reduce_seq.sv
// Sequential signed modulo-Q reducer, canonical or centered residue,
// fixed latency of STEPS+1 edges, valid/ready on both sides.
module modq_reduce_seq
  import modq_pkg::*;
#(
  parameter int N = 25,
  parameter int Q = Q_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         cent_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int QW    = qwidth(Q);
  localparam int STEPS = N - QW + 1;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [KW-1:0] K_TOP  = KW'(STEPS - 1);
  localparam logic [N-1:0]  Q_N    = N'(Q);
  localparam logic [N-1:0]  Q_HALF = N'(Q / 2);

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  mag;
  logic [N-1:0]  mag_step;
  logic [N-1:0]  in_mag;
  logic          sign;
  logic          mode;
  logic [KW-1:0] k;
  logic [N-1:0]  r_n;
  logic [N-1:0]  fix_val;
  logic [N-1:0]  out_q;

  modq_csub_step #(
    .N  (N),
    .Q  (Q),
    .KW (KW)
  ) u_step (
    .mag    (mag),
    .k      (k),
    .mag_nx (mag_step)
  );

  // Magnitude of the operand; the most negative value wraps to 2^(N-1).
  always_comb begin
    in_mag = in_data[N-1] ? (~in_data + N'(1)) : in_data;
  end

  // Undo the sign on the residue, then fold to centered range if asked.
  always_comb begin
    r_n     = (sign && (mag != '0)) ? (Q_N - mag) : mag;
    fix_val = (mode && (r_n > Q_HALF)) ? (r_n - Q_N) : r_n;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = REDUCE;
      REDUCE:  if (k == '0)   state_nx = FIX;
      FIX:                    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mag   <= '0;
      sign  <= 1'b0;
      mode  <= 1'b0;
      k     <= '0;
      out_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mag  <= in_mag;
            sign <= in_data[N-1];
            mode <= cent_mode;
            k    <= K_TOP;
          end
        end
        REDUCE: begin
          mag <= mag_step;
          if (k != '0) k <= k - KW'(1);
        end
        FIX:     out_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = out_q;

endmodule
